// File: rtl/pri_encoder_pkg.sv
// Shared constants, helpers and types for the pri_encoder_pipe block.
package pri_encoder_pkg;

  localparam int MAX_N     = 64;
  localparam int MAX_IDX_W = $clog2(MAX_N);

  // Handshake status of the output side, for monitors.
  typedef enum logic [1:0] {
    HS_IDLE  = 2'd0,
    HS_XFER  = 2'd1,
    HS_STALL = 2'd2
  } hs_status_e;

  // One-hot vector with bit idx set; all zeros if idx is outside 0..n-1.
  function automatic logic [MAX_N-1:0] onehot_from_idx(input logic [MAX_IDX_W-1:0] idx,
                                                       input int n);
    onehot_from_idx = '0;
    if (int'(idx) < n) onehot_from_idx[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/pri_enc_core.sv
// Purely combinational N-bit priority encoder; MSB_FIRST selects which end wins.
module pri_enc_core
  import pri_encoder_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic [N-1:0]         grant,
  output logic                 any
);

  localparam int IDX_W = $clog2(N);

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    idx = '0;
    if (MSB_FIRST) begin
      // Later iterations overwrite earlier ones, so the highest set bit wins.
      for (int i = 0; i < N; i++)
        if (req[i]) idx = IDX_W'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (req[i]) idx = IDX_W'(i);
    end
    any   = |req;
    grant = any ? N'(onehot_from_idx(MAX_IDX_W'(idx), N)) : '0;
  end

endmodule

// File: rtl/pri_encoder_pipe.sv
// Registered N-input priority encoder with valid/ready on both sides.
// Define PRI_ENCODER_PIPE_RR_EN for round-robin priority rotation.
module pri_encoder_pipe
  import pri_encoder_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] idx,
  output logic [N-1:0]         grant,
  output logic                 none
);

  localparam int IDX_W = $clog2(N);

  logic             accept;
  logic [IDX_W-1:0] nxt_idx;
  logic [N-1:0]     nxt_grant;
  logic             nxt_any;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef PRI_ENCODER_PIPE_RR_EN
  logic [IDX_W-1:0] ptr;
  logic [N-1:0]     mask;
  logic [IDX_W-1:0] m_idx, u_idx;
  logic [N-1:0]     m_grant, u_grant;
  logic             m_any, u_any;

  // Mask off the last winner and everything ahead of it in priority order.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++)
      mask[i] = MSB_FIRST ? (i < int'(ptr)) : (i > int'(ptr));
  end

  pri_enc_core #(.N(N), .MSB_FIRST(MSB_FIRST)) u_masked (
    .req   (req & mask),
    .idx   (m_idx),
    .grant (m_grant),
    .any   (m_any)
  );

  pri_enc_core #(.N(N), .MSB_FIRST(MSB_FIRST)) u_full (
    .req   (req),
    .idx   (u_idx),
    .grant (u_grant),
    .any   (u_any)
  );

  assign nxt_idx   = m_any ? m_idx   : u_idx;
  assign nxt_grant = m_any ? m_grant : u_grant;
  assign nxt_any   = u_any;

  // Reset value leaves the mask empty so the first grant is fixed priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= MSB_FIRST ? '0 : IDX_W'(N - 1);
    else if (accept && nxt_any)
      ptr <= nxt_idx;
  end
`else
  pri_enc_core #(.N(N), .MSB_FIRST(MSB_FIRST)) u_core (
    .req   (req),
    .idx   (nxt_idx),
    .grant (nxt_grant),
    .any   (nxt_any)
  );
`endif

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      idx       <= '0;
      grant     <= '0;
      none      <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      idx       <= nxt_idx;
      grant     <= nxt_grant;
      none      <= !nxt_any;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
